cnn_tile_loader: RTL and testbench
==================================

// Module: cnn_tile_loader
// PURPOSE
//  Streams the input feature map from the word-addressed feature-map memory into the cnn compute
//  engine, one Tn_p-channel pixel vector per handshake beat.
//  Sits between mem (input_fm storage) and cnn.
//  Moves raw 32-bit words (shortreal bit patterns) only; no arithmetic on data.
//  Zero-pads the last channel tile when N_p is not a multiple of Tn_p.
// PARAMETERS
//  N_p   1  input channels
//  R_p   4  feature-map rows
//  C_p   4  feature-map columns
//  Tn_p  1  channels per beat (lanes); 1 <= Tn_p <= N_p
//  AW_p  $clog2(N_p*R_p*C_p) (min 1)  read-address width
// PORTS
//  clk_i         in   1        clock, rising edge
//  reset_i       in   1        asynchronous, active-low reset
//  start_i       in   1        1-cycle pulse: begin one full pass of the feature map
//  busy_o        out  1        high from cycle after accepted start until done_o cycle (inclusive)
//  done_o        out  1        1-cycle pulse, cycle after last beat handshake
//  rd_en_o       out  1        memory read strobe
//  rd_addr_o     out  AW_p     word address = n*R_p*C_p + r*C_p + c
//  rd_data_i     in   32       read data, valid exactly 1 cycle after rd_en_o
//  tile_valid_o  out  1        beat valid
//  tile_ready_i  in   1        consumer ready; transfer when valid & ready
//  tile_data_o   out  Tn_p*32  lane l in bits [32*l +: 32], lane l = channel n0+l
//  tile_n_o      out  clog2(ceil(N_p/Tn_p)) (min 1)  channel-tile index of beat
//  tile_r_o      out  clog2(R_p) (min 1)  row of beat
//  tile_c_o      out  clog2(C_p) (min 1)  column of beat
//  tile_last_o   out  1        high on final beat of the pass
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE. busy_o, done_o, rd_en_o, tile_valid_o and
//   tile_last_o are 0; rd_addr_o, tile_data_o and tile_n/r/c_o are 0.
//  Iteration order: for tile t in 0..ceil(N_p/Tn_p)-1, for r, for c (c fastest).
//   One beat per (t,r,c).
//  States:
//   IDLE  -> FETCH on start_i.
//   FETCH: lane counter l = 0..Tn_p-1, one lane per cycle.
//    If channel n0+l < N_p: rd_en_o=1 with that lane's address.
//    Otherwise rd_en_o=0 and the lane is written 0 (pad).
//    Returned data is written to lane l-1 the following cycle.
//    After lane Tn_p-1 is issued -> DRAIN (1 cycle, captures last lane).
//   DRAIN -> HOLD.
//   HOLD: tile_valid_o=1. On tile_ready_i: next (t,r,c); FETCH, or DONE after the last beat.
//   DONE: done_o=1, busy_o=1 -> IDLE.
//  Latency: a beat is valid Tn_p+1 cycles after entering FETCH.
//   First beat: Tn_p+2 cycles after the start_i cycle.
//  Handshake: tile_data_o and tile_n/r/c/last_o stay stable while valid & !ready.
//   tile_valid_o never drops without a transfer.
//   Ready already high when valid rises: transfer in that same cycle.
//   Ready while !valid: ignored.
//  start_i while busy_o: ignored, no restart.
//   start_i in the DONE cycle: ignored; must be re-asserted in IDLE.
//  rd_en_o never asserted outside FETCH; no read is issued for pad lanes.
//  Reset mid-pass: immediate abort to reset values; the in-flight read is discarded.
//  Counter wrap: c wraps to 0 and increments r; r wraps and increments t.
//   Wrap of t coincides with tile_last_o.
// STRUCTURE
//  cnn_pkg (shared):
//   - typedef logic [31:0] word_t
//   - loader state enum {IDLE,FETCH,DRAIN,HOLD,DONE}
//   - function ceil_div(a,b)
//  Sub-module cnn_loop_counter:
//   - params MAX; ports clk_i, reset_i, en_i, clr_i, cnt_o, wrap_o
//   - instanced for l, c, r and t
//  Address computation and lane buffer stay in cnn_tile_loader.
// TESTING  (mem model: word at addr a = a+1, 1-cycle read latency)
//  Test 1 (N=1,R=4,C=4,Tn=1): start, ready held 1
//   -> 16 beats with data 1..16 in order; tile_last_o on beat 16.
//   -> done_o 1 cycle after beat 16, then busy_o=0.
//  Test 2 (N=3,R=2,C=2,Tn=2): 8 beats.
//   -> beat0 lanes {1,5}; beat3 {4,8}; beat4 {9,0}; beat7 {12,0}.
//   -> rd_en_o asserted exactly 12 times.
//  Test 3 (backpressure): tile_ready_i held 0 for 10 cycles on beat0.
//   -> valid stays 1; data/indices unchanged; no rd_en_o during the hold.
//  Test 4 (start while busy): second start_i mid-pass
//   -> beat count unchanged; exactly one done_o.
//  Test 5 (reset_i low mid-FETCH): all outputs at reset values asynchronously.
//   -> A new start after reset release yields a full correct pass from beat0.
//  Test 6 (latency, Tn=2): tile_valid_o rises exactly 4 cycles after the start_i cycle.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and elaboration helpers for the cnn feature-map datapath.
package cnn_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, DONE} loader_state_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Index width for a range of v values; a single-value range still needs one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/cnn_tile_loader_if.sv
// Feature-map read port plus tile-stream handshake between the loader, memory and compute engine.
interface cnn_tile_loader_if #(
  parameter int unsigned TN = 1,
  parameter int unsigned AW = 4,
  parameter int unsigned NW = 1,
  parameter int unsigned RW = 2,
  parameter int unsigned CW = 2
) ();
  import cnn_pkg::*;

  logic             rd_en_o;
  logic [AW-1:0]    rd_addr_o;
  word_t            rd_data_i;
  logic             tile_valid_o;
  logic             tile_ready_i;
  logic [TN*32-1:0] tile_data_o;
  logic [NW-1:0]    tile_n_o;
  logic [RW-1:0]    tile_r_o;
  logic [CW-1:0]    tile_c_o;
  logic             tile_last_o;

  modport master (
    output rd_en_o, rd_addr_o,
    input  rd_data_i,
    output tile_valid_o, tile_data_o, tile_n_o, tile_r_o, tile_c_o, tile_last_o,
    input  tile_ready_i
  );

  modport slave (
    input  rd_en_o, rd_addr_o,
    output rd_data_i,
    input  tile_valid_o, tile_data_o, tile_n_o, tile_r_o, tile_c_o, tile_last_o,
    output tile_ready_i
  );

endinterface

// File: rtl/cnn_loop_counter.sv
// Modulo-MAX loop counter; wrap_o flags the enabled step that returns the count to zero.
module cnn_loop_counter
  import cnn_pkg::*;
#(
  parameter int unsigned MAX = 2,
  localparam int unsigned W = clog2_min1(MAX)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  assign wrap_o = en_i && (cnt_o == W'(MAX - 1));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= wrap_o ? '0 : cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/cnn_tile_loader.sv
// Streams the input feature map from memory to the compute engine, one Tn_p-lane pixel
// vector per beat, zero-padding lanes beyond the last channel.
module cnn_tile_loader
  import cnn_pkg::*;
#(
  parameter int unsigned N_p  = 1,
  parameter int unsigned R_p  = 4,
  parameter int unsigned C_p  = 4,
  parameter int unsigned Tn_p = 1,
  parameter int unsigned AW_p = clog2_min1(N_p * R_p * C_p)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  cnn_tile_loader_if.master bus
);

  localparam int unsigned NT = ceil_div(N_p, Tn_p);
  localparam int unsigned LW = clog2_min1(Tn_p);
  localparam int unsigned NW = clog2_min1(NT);
  localparam int unsigned RW = clog2_min1(R_p);
  localparam int unsigned CW = clog2_min1(C_p);

  loader_state_t   r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_valid;
  logic            r_last;
  word_t           r_lane [Tn_p];
  logic            r_cap_valid;
  logic [LW-1:0]   r_cap_lane;

  logic [LW-1:0]   w_l;
  logic [NW-1:0]   w_t;
  logic [RW-1:0]   w_r;
  logic [CW-1:0]   w_c;
  logic            w_l_wrap, w_c_wrap, w_r_wrap, w_t_wrap;
  logic            w_fetch, w_start, w_xfer, w_at_last, w_lane_active, w_rd_en;
  logic [31:0]     w_ch;
  logic [Tn_p*32-1:0] w_data;

  assign w_fetch = (r_state == FETCH);
  assign w_start = (r_state == IDLE) && start_i;
  assign w_xfer  = (r_state == HOLD) && bus.tile_ready_i;

  cnn_loop_counter #(.MAX(Tn_p)) u_lane (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(w_fetch), .clr_i(w_start),
    .cnt_o(w_l), .wrap_o(w_l_wrap));

  cnn_loop_counter #(.MAX(C_p)) u_col (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(w_xfer), .clr_i(w_start),
    .cnt_o(w_c), .wrap_o(w_c_wrap));

  cnn_loop_counter #(.MAX(R_p)) u_row (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(w_c_wrap), .clr_i(w_start),
    .cnt_o(w_r), .wrap_o(w_r_wrap));

  cnn_loop_counter #(.MAX(NT)) u_tile (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(w_r_wrap), .clr_i(w_start),
    .cnt_o(w_t), .wrap_o(w_t_wrap));

  assign w_ch          = 32'(w_t) * Tn_p + 32'(w_l);
  assign w_lane_active = (w_ch < N_p);
  assign w_rd_en       = w_fetch && w_lane_active;
  assign w_at_last     = (w_t == NW'(NT - 1)) && (w_r == RW'(R_p - 1)) && (w_c == CW'(C_p - 1));

  assign bus.rd_en_o   = w_rd_en;
  assign bus.rd_addr_o = w_rd_en ? AW_p'(w_ch * (R_p * C_p) + 32'(w_r) * C_p + 32'(w_c)) : '0;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= FETCH;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (w_l_wrap) r_state <= DRAIN;
        end
        DRAIN: begin
          r_state <= HOLD;
          r_valid <= 1'b1;
          r_last  <= w_at_last;
        end
        HOLD: begin
          if (bus.tile_ready_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (w_t_wrap) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= FETCH;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data lands one cycle after its strobe, so the lane index travels with r_cap_valid;
  // pad lanes are cleared in their own FETCH cycle since no read returns for them.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cap_valid <= 1'b0;
      r_cap_lane  <= '0;
      for (int unsigned i = 0; i < Tn_p; i++) r_lane[i] <= '0;
    end else begin
      r_cap_valid <= w_rd_en;
      if (w_rd_en) r_cap_lane <= w_l;
      for (int unsigned i = 0; i < Tn_p; i++) begin
        if (r_cap_valid && (32'(r_cap_lane) == i)) begin
          r_lane[i] <= bus.rd_data_i;
        end else if (w_fetch && !w_lane_active && (32'(w_l) == i)) begin
          r_lane[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int unsigned i = 0; i < Tn_p; i++) w_data[32*i +: 32] = r_lane[i];
  end

  assign bus.tile_valid_o = r_valid;
  assign bus.tile_data_o  = w_data;
  assign bus.tile_n_o     = w_t;
  assign bus.tile_r_o     = w_r;
  assign bus.tile_c_o     = w_c;
  assign bus.tile_last_o  = r_last;
  assign busy_o           = r_busy;
  assign done_o           = r_done;

endmodule

// File: tb/tb_cnn_tile_loader.sv
// Scoreboard bench for cnn_tile_loader: two configurations, directed passes with hand-computed beats.
module tb_cnn_tile_loader;
  import cnn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;

  cnn_tile_loader_if #(.TN(1), .AW(4), .NW(1), .RW(2), .CW(2)) bus_a ();
  cnn_tile_loader_if #(.TN(2), .AW(4), .NW(1), .RW(1), .CW(1)) bus_b ();

  cnn_tile_loader #(.N_p(1), .R_p(4), .C_p(4), .Tn_p(1)) dut_a (
    .clk_i(clk), .reset_i(rst_n), .start_i(start_a), .busy_o(busy_a), .done_o(done_a), .bus(bus_a));

  cnn_tile_loader #(.N_p(3), .R_p(2), .C_p(2), .Tn_p(2)) dut_b (
    .clk_i(clk), .reset_i(rst_n), .start_i(start_b), .busy_o(busy_b), .done_o(done_b), .bus(bus_b));

  // memory: word at address a holds a+1, one-cycle read latency
  always @(posedge clk) begin
    bus_a.rd_data_i <= bus_a.rd_en_o ? 32'(bus_a.rd_addr_o) + 32'd1 : 32'd0;
    bus_b.rd_data_i <= bus_b.rd_en_o ? 32'(bus_b.rd_addr_o) + 32'd1 : 32'd0;
  end

  typedef struct {
    logic [63:0] data;
    logic [31:0] idx;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int errors = 0, checks = 0;
  int cyc = 0;
  int beats_a = 0, beats_b = 0, dones_a = 0, dones_b = 0, rdcnt_b = 0;
  int lastx_a = -100, lastx_b = -100;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int n, input int r, input int c, input bit last);
    return {8'(last), 8'(n), 8'(r), 8'(c)};
  endfunction

  // Pass B (N=3,R=2,C=2,Tn=2): lane1 in the upper word, pad lanes are zero.
  logic [63:0] exp_b [8] = '{64'h00000005_00000001, 64'h00000006_00000002,
                             64'h00000007_00000003, 64'h00000008_00000004,
                             64'h00000000_00000009, 64'h00000000_0000000a,
                             64'h00000000_0000000b, 64'h00000000_0000000c};

  task automatic push_a_pass();
    beat_t e;
    for (int p = 0; p < 16; p++) begin
      e.data = 64'(p + 1);
      e.idx  = pk(0, p / 4, p % 4, p == 15);
      qa.push_back(e);
    end
  endtask

  task automatic push_b_pass();
    beat_t e;
    for (int p = 0; p < 8; p++) begin
      e.data = exp_b[p];
      e.idx  = pk(p / 4, (p / 2) % 2, p % 2, p == 7);
      qb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (bus_a.tile_valid_o && bus_a.tile_ready_i) begin
        beats_a++;
        if (qa.size() == 0) check("a_unexpected_beat", 64'(qa.size()), 64'd1);
        else begin
          e = qa.pop_front();
          check("a_data", 64'(bus_a.tile_data_o), e.data);
          check("a_idx", 64'(pk(int'(bus_a.tile_n_o), int'(bus_a.tile_r_o),
                                int'(bus_a.tile_c_o), bus_a.tile_last_o)), 64'(e.idx));
        end
        if (bus_a.tile_last_o) lastx_a = cyc;
      end
      if (done_a) begin
        dones_a++;
        check("a_done_latency", 64'(cyc), 64'(lastx_a + 1));
        check("a_busy_in_done", 64'(busy_a), 64'd1);
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (bus_b.rd_en_o) rdcnt_b++;
      if (bus_b.tile_valid_o && bus_b.tile_ready_i) begin
        beats_b++;
        if (qb.size() == 0) check("b_unexpected_beat", 64'(qb.size()), 64'd1);
        else begin
          e = qb.pop_front();
          check("b_data", 64'(bus_b.tile_data_o), e.data);
          check("b_idx", 64'(pk(int'(bus_b.tile_n_o), int'(bus_b.tile_r_o),
                                int'(bus_b.tile_c_o), bus_b.tile_last_o)), 64'(e.idx));
        end
        if (bus_b.tile_last_o) lastx_b = cyc;
      end
      if (done_b) begin
        dones_b++;
        check("b_done_latency", 64'(cyc), 64'(lastx_b + 1));
        check("b_busy_in_done", 64'(busy_b), 64'd1);
      end
    end
  end

  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) begin
        @(negedge clk);
        check({nm, "_busy_after_done"}, 64'(sel ? busy_b : busy_a), 64'd0);
        return;
      end
    end
    check({nm, "_done_timeout"}, 64'(sel ? done_b : done_a), 64'd1);
  endtask

  task automatic check_reset_b(input string p);
    check({p, "_busy"},  64'(busy_b), 64'd0);
    check({p, "_done"},  64'(done_b), 64'd0);
    check({p, "_rd_en"}, 64'(bus_b.rd_en_o), 64'd0);
    check({p, "_addr"},  64'(bus_b.rd_addr_o), 64'd0);
    check({p, "_valid"}, 64'(bus_b.tile_valid_o), 64'd0);
    check({p, "_last"},  64'(bus_b.tile_last_o), 64'd0);
    check({p, "_data"},  64'(bus_b.tile_data_o), 64'd0);
    check({p, "_nrc"},   64'(pk(int'(bus_b.tile_n_o), int'(bus_b.tile_r_o),
                                int'(bus_b.tile_c_o), 1'b0)), 64'd0);
  endtask

  initial begin
    int lat, b0, d0;
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.tile_ready_i = 1'b0;
    bus_b.tile_ready_i = 1'b0;

    #12;
    check_reset_b("reset");
    check("reset_a_valid", 64'(bus_a.tile_valid_o), 64'd0);
    check("reset_a_busy", 64'(busy_a), 64'd0);
    #10 rst_n = 1'b1;

    // Test 1: N=1,R=4,C=4,Tn=1, ready held high
    bus_a.tile_ready_i = 1'b1;
    push_a_pass();
    pulse_start(1'b0);
    wait_done(1'b0, 200, "t1");
    check("t1_beats", 64'(beats_a), 64'd16);
    check("t1_dones", 64'(dones_a), 64'd1);
    check("t1_queue_empty", 64'(qa.size()), 64'd0);

    // Test 2 + latency: N=3,R=2,C=2,Tn=2
    bus_b.tile_ready_i = 1'b1;
    rdcnt_b = 0;
    push_b_pass();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    lat = 1;
    while (!bus_b.tile_valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t6_valid_latency", 64'(lat), 64'd4);
    wait_done(1'b1, 200, "t2");
    check("t2_rd_en_count", 64'(rdcnt_b), 64'd12);
    check("t2_beats", 64'(beats_b), 64'd8);
    check("t2_queue_empty", 64'(qb.size()), 64'd0);

    // Test 3: backpressure on beat0
    bus_b.tile_ready_i = 1'b0;
    push_b_pass();
    pulse_start(1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_b.tile_valid_o) break;
    end
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", 64'(bus_b.tile_valid_o), 64'd1);
      check("t3_hold_data", 64'(bus_b.tile_data_o), exp_b[0]);
      check("t3_hold_idx", 64'(pk(int'(bus_b.tile_n_o), int'(bus_b.tile_r_o),
                                  int'(bus_b.tile_c_o), bus_b.tile_last_o)), 64'd0);
      check("t3_hold_no_read", 64'(bus_b.rd_en_o), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 bus_b.tile_ready_i = 1'b1;
    wait_done(1'b1, 200, "t3");
    check("t3_queue_empty", 64'(qb.size()), 64'd0);

    // Test 4: start while busy is ignored
    b0 = beats_b;
    d0 = dones_b;
    push_b_pass();
    pulse_start(1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (beats_b >= b0 + 3) break;
    end
    pulse_start(1'b1);
    wait_done(1'b1, 200, "t4");
    repeat (20) @(negedge clk);
    check("t4_dones", 64'(dones_b - d0), 64'd1);
    check("t4_beats", 64'(beats_b - b0), 64'd8);
    check("t4_queue_empty", 64'(qb.size()), 64'd0);

    // Test 5: reset during the FETCH of beat1
    push_b_pass();
    pulse_start(1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus_b.rd_en_o && bus_b.tile_c_o == 1'b1) break;
    end
    check("t5_in_fetch", 64'(bus_b.rd_en_o), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_b("t5_async");
    qb.delete();
    #10 rst_n = 1'b1;
    b0 = beats_b;
    push_b_pass();
    pulse_start(1'b1);
    wait_done(1'b1, 200, "t5");
    check("t5_beats", 64'(beats_b - b0), 64'd8);
    check("t5_queue_empty", 64'(qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
